// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result handshake bundle for the multi-cycle ALU.
// master = issuing stage, slave = alu_mc.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [5:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             great;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, alu_op, a, b, shamt, out_ready,
        input  in_ready, out_valid, out, zero, great, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, alu_op, a, b, shamt, out_ready,
        output in_ready, out_valid, out, zero, great, overflow, div_by_zero
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU. Simple ops finish in one clock;
// multiply/divide run on a shared iterative datapath (shift-add multiply,
// restoring divide) followed by a sign-fix step. Results and flags are
// registered and held until the consumer takes them.
// Optional build macro: ALU_MC_FAST_MUL_EN -- multiplies become single-cycle
// combinational ops; divides stay iterative.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    // Opcode values match the ALU_OP_* encodings used by the decoder.
    localparam logic [5:0] OP_SLL  = 6'h00, OP_ROTR  = 6'h01, OP_SRL  = 6'h02,
                           OP_SRA  = 6'h03, OP_SLLV  = 6'h04, OP_ROTRV = 6'h05,
                           OP_SRLV = 6'h06, OP_SRAV  = 6'h07,
                           OP_MUL  = 6'h18, OP_MUH   = 6'h19, OP_MULU = 6'h1A,
                           OP_MUHU = 6'h1B, OP_DIV   = 6'h1C, OP_MOD  = 6'h1D,
                           OP_DIVU = 6'h1E, OP_MODU  = 6'h1F,
                           OP_ADD  = 6'h20, OP_ADDU  = 6'h21, OP_SUB  = 6'h22,
                           OP_SUBU = 6'h23, OP_AND   = 6'h24, OP_OR   = 6'h25,
                           OP_XOR  = 6'h26, OP_NOR   = 6'h27, OP_SLT  = 6'h2A,
                           OP_SLTU = 6'h2B;

    localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH-1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t           state;
    logic [5:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] hi, lo, dvsr;   // hi:lo = product, or remainder:quotient
    logic [SHW:0]     cnt;
    logic             neg_q, neg_r, dz;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q, zero_q, great_q, ovf_q, dbz_q;

    logic [WIDTH-1:0] op_a, op_b;
    logic             accept, in_mul, in_div, in_signed, in_iter;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_a   = bus.a;
    assign op_b   = bus.b;
    assign bus.in_ready    = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out         = out_q;
    assign bus.zero        = zero_q;
    assign bus.great       = great_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v,
                                              input logic [SHW-1:0] s);
        logic [2*WIDTH-1:0] t;
        t = {v, v} >> s;
        return t[WIDTH-1:0];
    endfunction

    // Decode of the incoming request and operand magnitudes for signed ops
    always_comb begin
        in_mul    = (bus.alu_op inside {OP_MUL, OP_MUH, OP_MULU, OP_MUHU});
        in_div    = (bus.alu_op inside {OP_DIV, OP_MOD, OP_DIVU, OP_MODU});
        in_signed = (bus.alu_op inside {OP_MUL, OP_MUH, OP_DIV, OP_MOD});
`ifdef ALU_MC_FAST_MUL_EN
        in_iter   = in_div;
`else
        in_iter   = in_div || in_mul;
`endif
        a_mag = (in_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        b_mag = (in_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    end

`ifdef ALU_MC_FAST_MUL_EN
    logic [2*WIDTH-1:0] f_mag, f_prod;
    assign f_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    assign f_prod = (in_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1])) ? -f_mag : f_mag;
`endif

    // Single-cycle result, computed from the request as it is accepted
    logic [WIDTH-1:0] s_res, sum, dif;
    logic             s_ovf;
    always_comb begin
        sum   = op_a + op_b;
        dif   = op_a - op_b;
        s_res = '0;
        s_ovf = 1'b0;
        case (bus.alu_op)
            OP_ADD:   begin
                s_res = sum;
                s_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_ADDU:  s_res = sum;
            OP_SUB:   begin
                s_res = dif;
                s_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUBU:  s_res = dif;
            OP_AND:   s_res = op_a & op_b;
            OP_OR:    s_res = op_a | op_b;
            OP_NOR:   s_res = ~(op_a | op_b);
            OP_XOR:   s_res = op_a ^ op_b;
            OP_SLT:   s_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:  s_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            OP_SLL:   s_res = op_b << bus.shamt;
            OP_SRL:   s_res = op_b >> bus.shamt;
            OP_SRA:   s_res = $unsigned($signed(op_b) >>> bus.shamt);
            OP_ROTR:  s_res = rotr(op_b, bus.shamt);
            OP_SLLV:  s_res = op_b << op_a[SHW-1:0];
            OP_SRLV:  s_res = op_b >> op_a[SHW-1:0];
            OP_SRAV:  s_res = $unsigned($signed(op_b) >>> op_a[SHW-1:0]);
            OP_ROTRV: s_res = rotr(op_b, op_a[SHW-1:0]);
`ifdef ALU_MC_FAST_MUL_EN
            OP_MUL, OP_MULU: s_res = f_prod[WIDTH-1:0];
            OP_MUH, OP_MUHU: s_res = f_prod[2*WIDTH-1:WIDTH];
`endif
            default:  s_res = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide
    logic [WIDTH:0]   m_sum, d_rs, d_df;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             q_div;
    always_comb begin
        q_div = (op_q inside {OP_DIV, OP_MOD, OP_DIVU, OP_MODU});
        m_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : '0);
        d_rs  = {hi, lo[WIDTH-1]};
        d_df  = d_rs - {1'b0, dvsr};
        if (!q_div)
            {hi_n, lo_n} = {m_sum, lo[WIDTH-1:1]};
        else if (!d_df[WIDTH])
            {hi_n, lo_n} = {d_df[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
        else
            {hi_n, lo_n} = {d_rs[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end

    // Sign correction and result select for iterative ops
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo, rem, f_res;
    always_comb begin
        prod_s = neg_q ? -{hi, lo} : {hi, lo};
        quo    = neg_q ? -lo : lo;
        rem    = neg_r ? -hi : hi;
        case (op_q)
            OP_MUL, OP_MULU: f_res = prod_s[WIDTH-1:0];
            OP_MUH, OP_MUHU: f_res = prod_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: f_res = dz ? '1 : quo;
            OP_MOD, OP_MODU: f_res = dz ? a_q : rem;
            default:         f_res = '0;
        endcase
    end

    // Control FSM with registered result and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            hi          <= '0;
            lo          <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            great_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) state <= FIX;
                end
                FIX: begin
                    out_q       <= f_res;
                    zero_q      <= (f_res == '0);
                    great_q     <= !f_res[WIDTH-1] && (f_res != '0);
                    ovf_q       <= 1'b0;
                    dbz_q       <= dz;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready && !bus.in_valid) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: ;
            endcase
            // An accept overrides whatever DONE decided on the same edge
            if (accept) begin
                op_q <= bus.alu_op;
                a_q  <= op_a;
                if (in_iter) begin
                    hi          <= '0;
                    lo          <= in_div ? a_mag : b_mag;
                    dvsr        <= in_div ? b_mag : a_mag;
                    cnt         <= '0;
                    neg_q       <= in_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    neg_r       <= in_signed && op_a[WIDTH-1];
                    dz          <= in_div && (op_b == '0);
                    out_valid_q <= 1'b0;
                    state       <= BUSY;
                end else begin
                    out_q       <= s_res;
                    zero_q      <= (s_res == '0);
                    great_q     <= !s_res[WIDTH-1] && (s_res != '0);
                    ovf_q       <= s_ovf;
                    dbz_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed + randomized checks of alu_mc against an arithmetic
// reference model (results, flags, latency, hold, back-to-back, reset abort).
module tb_alu_mc;
    localparam logic [5:0] SLL = 6'h00, ROTR = 6'h01, SRL = 6'h02, SRA = 6'h03,
                           SLLV = 6'h04, ROTRV = 6'h05, SRLV = 6'h06, SRAV = 6'h07,
                           MUL = 6'h18, MUH = 6'h19, MULU = 6'h1A, MUHU = 6'h1B,
                           DIV = 6'h1C, MOD = 6'h1D, DIVU = 6'h1E, MODU = 6'h1F,
                           ADD = 6'h20, ADDU = 6'h21, SUB = 6'h22, SUBU = 6'h23,
                           AND_ = 6'h24, OR_ = 6'h25, XOR_ = 6'h26, NOR_ = 6'h27,
                           SLT = 6'h2A, SLTU = 6'h2B;
`ifdef ALU_MC_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    alu_mc_if #(.WIDTH(32)) bus ();
    alu_mc dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish within 1ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the operand values
    function automatic void model(input logic [5:0] op, input logic [31:0] a, b,
                                  input logic [4:0] sh, output logic [31:0] r,
                                  output logic ov, output logic dz, output int lat);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint sp;
        logic [63:0] up;
        r = 0; ov = 0; dz = 0; lat = 1;
        case (op)
            ADD:  begin r = a + b; ov = (sa + sb > 64'sd2147483647) || (sa + sb < -64'sd2147483648); end
            ADDU: r = a + b;
            SUB:  begin r = a - b; ov = (sa - sb > 64'sd2147483647) || (sa - sb < -64'sd2147483648); end
            SUBU: r = a - b;
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            NOR_: r = ~(a | b);
            SLT:  r = (sa < sb) ? 1 : 0;
            SLTU: r = (a < b) ? 1 : 0;
            SLL:  r = b << sh;
            SRL:  r = b >> sh;
            SRA:  r = 32'(sb >>> sh);
            ROTR: begin r = b; repeat (sh) r = {r[0], r[31:1]}; end
            SLLV: r = b << a[4:0];
            SRLV: r = b >> a[4:0];
            SRAV: r = 32'(sb >>> a[4:0]);
            ROTRV: begin r = b; repeat (a[4:0]) r = {r[0], r[31:1]}; end
            MUL, MUH, MULU, MUHU: begin
                lat = MUL_LAT;
                if (op == MUL || op == MUH) begin sp = sa * sb; up = sp; end
                else up = {32'b0, a} * {32'b0, b};
                r = (op == MUL || op == MULU) ? up[31:0] : up[63:32];
            end
            DIV, MOD, DIVU, MODU: begin
                lat = 34;
                if (b == 0) begin
                    dz = 1;
                    r = (op == DIV || op == DIVU) ? 32'hFFFF_FFFF : a;
                end else if (op == DIV) r = 32'(sa / sb);
                else if (op == MOD) r = 32'(sa % sb);
                else if (op == DIVU) r = a / b;
                else r = a % b;
            end
            default: r = 0;
        endcase
    endfunction

    // Issue one op, wait for its result, check everything; optionally take it
    task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] a, b,
                         input logic [4:0] sh, input bit take);
        logic [31:0] r; logic ov, dz; int lat, n;
        model(op, a, b, sh, r, ov, dz, lat);
        @(negedge clk);
        bus.in_valid = 1; bus.alu_op = op; bus.a = a; bus.b = b; bus.shamt = sh;
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 0; bus.alu_op = 6'($urandom); bus.a = $urandom; bus.b = $urandom;
        bus.shamt = 5'($urandom);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1; n++;
            if (n == 2) check({tag, " busy in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " out"}, 64'(bus.out), 64'(r));
        check({tag, " zero"}, 64'(bus.zero), 64'(r == 0));
        check({tag, " great"}, 64'(bus.great), 64'($signed(r) > 0));
        check({tag, " overflow"}, 64'(bus.overflow), 64'(ov));
        check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(dz));
        if (take) begin
            @(negedge clk); bus.out_ready = 1;
            @(posedge clk); #1; bus.out_ready = 0;
            check({tag, " drained"}, 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        logic [5:0] ops[26] = '{SLL, ROTR, SRL, SRA, SLLV, ROTRV, SRLV, SRAV, MUL, MUH,
                                MULU, MUHU, DIV, MOD, DIVU, MODU, ADD, ADDU, SUB, SUBU,
                                AND_, OR_, XOR_, NOR_, SLT, SLTU};
        logic [31:0] ra, rb, hold_out, r;
        logic hz, hg, ho, hd, ov, dz;
        int lat;

        bus.in_valid = 0; bus.out_ready = 0; bus.alu_op = 0;
        bus.a = 0; bus.b = 0; bus.shamt = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst out", 64'(bus.out), 64'd0);
        check("rst zero", 64'(bus.zero), 64'd1);
        check("rst great", 64'(bus.great), 64'd0);
        check("rst flags", 64'({bus.overflow, bus.div_by_zero}), 64'd0);
        @(negedge clk); rst = 0; #1;
        check("rst in_ready", 64'(bus.in_ready), 64'd1);

        issue("add ovf", ADD, 32'h7FFF_FFFF, 32'h1, 0, 1);
        issue("addu", ADDU, 32'h7FFF_FFFF, 32'h1, 0, 1);
        issue("sub ovf", SUB, 32'h8000_0000, 32'h1, 0, 1);
        issue("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 0, 1);
        issue("mod -7%2", MOD, 32'hFFFF_FFF9, 32'd2, 0, 1);
        issue("divu /0", DIVU, 32'd5, 32'd0, 0, 1);
        issue("modu /0", MODU, 32'd5, 32'd0, 0, 1);
        issue("div /0", DIV, 32'hFFFF_FFF0, 32'd0, 0, 1);
        issue("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        issue("mod min/-1", MOD, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        issue("mulu", MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
        issue("muhu", MUHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
        issue("muh min*min", MUH, 32'h8000_0000, 32'h8000_0000, 0, 1);
        issue("mul neg", MUL, 32'hFFFF_FFFD, 32'd7, 0, 1);
        issue("rotr", ROTR, 32'h8000_0001, 32'h8000_0001, 5'd1, 1);
        issue("srav", SRAV, 32'd36, 32'h8000_0000, 0, 1);
        issue("unknown op", 6'h3F, 32'h1234, 32'h5678, 0, 1);

        // Hold result with out_ready low, then same-edge take + accept
        issue("hold sub", SUB, 32'd3, 32'd10, 0, 0);
        hold_out = bus.out; hz = bus.zero; hg = bus.great; ho = bus.overflow; hd = bus.div_by_zero;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold out", 64'(bus.out), 64'(hold_out));
            check("hold flags", 64'({bus.zero, bus.great, bus.overflow, bus.div_by_zero}),
                  64'({hz, hg, ho, hd}));
            check("hold in_ready", 64'(bus.in_ready), 64'd0);
        end
        model(ADD, 32'd40, 32'd2, 0, r, ov, dz, lat);
        @(negedge clk);
        bus.out_ready = 1; bus.in_valid = 1; bus.alu_op = ADD; bus.a = 32'd40; bus.b = 32'd2;
        #1 check("b2b in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 0; bus.out_ready = 0;
        check("b2b out_valid", 64'(bus.out_valid), 64'd1);
        check("b2b out", 64'(bus.out), 64'(r));
        @(negedge clk); bus.out_ready = 1;
        @(posedge clk); #1; bus.out_ready = 0;
        check("b2b drained", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of a divide aborts it
        @(negedge clk);
        bus.in_valid = 1; bus.alu_op = DIVU; bus.a = 32'd1000; bus.b = 32'd7;
        @(posedge clk); #1; bus.in_valid = 0;
        repeat (10) @(posedge clk);
        #1 rst = 1;
        #1;
        check("abort out_valid", 64'(bus.out_valid), 64'd0);
        check("abort zero", 64'(bus.zero), 64'd1);
        check("abort out", 64'(bus.out), 64'd0);
        @(negedge clk); rst = 0; #1;
        check("abort in_ready", 64'(bus.in_ready), 64'd1);
        issue("after abort", DIVU, 32'd1000, 32'd7, 0, 1);

        // Randomized ops against the model, including corner operands
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 19) == 0) ? 6'h3E : ops[$urandom_range(0, 25)];
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                default: ;
            endcase
            issue($sformatf("rand%0d op%0h", i, op), op, ra, rb, 5'($urandom), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
